mod_red_final_sub_ctl: RTL

- Output stage placed directly downstream of the mixed word-level Montgomery reducer.
- The reducer has a fixed latency and no stall input. This block tracks each in-flight product with a valid delay line, samples the reducer output T at the matching cycle, and applies the final conditional subtraction (T in [0,2q) -> [0,q)).
- Results are buffered in an in-order FIFO with a valid/ready output.
- Credit-based issue control throttles the upstream multiplier, so the non-stallable reducer can never overrun the FIFO.

---
 rtl/mod_red_final_sub_ctl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mod_red_final_sub_ctl.sv
// Final conditional subtraction and in-order result FIFO behind a fixed-latency, non-stallable reducer.
// Issue to res_valid_o takes RED_LAT+FF_SUB+1 cycles; issue is credit-gated so the FIFO never overruns.
module mod_red_final_sub_ctl #(
   parameter int Q_LEN      = 60,
   parameter int RED_LAT    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int FF_SUB     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [Q_LEN-1:0]              q,
   input  logic                          c_valid_i,
   output logic                          c_ready_o,
   input  logic [Q_LEN-1:0]              t_i,
   output logic [Q_LEN-1:0]              res_o,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   credits_o,
   output logic                          ovf_err_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW:0]        credits;
   logic               issue;
   logic               pop;
   logic [RED_LAT-1:0] vline;
   logic               t_vld;
   logic [Q_LEN:0]     d;
   logic [Q_LEN-1:0]   r;
   logic               push_vld;
   logic [Q_LEN-1:0]   push_dat;

   assign c_ready_o = (credits != '0);
   assign credits_o = credits;
   assign issue     = c_valid_i & c_ready_o;
   assign pop       = res_valid_o & res_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= CNT_MAX;
      end else if (issue & ~pop) begin
         credits <= credits - CNT_ONE;
      end else if (pop & ~issue) begin
         credits <= credits + CNT_ONE;
      end
   end

   // Tag-only delay line: the reducer carries the data, we only track which cycles are real.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vline <= '0;
      end else begin
         vline[0] <= issue;
         for (int i = 1; i < RED_LAT; i++) vline[i] <= vline[i-1];
      end
   end

   assign t_vld = vline[RED_LAT-1];
   assign d     = {1'b0, t_i} - {1'b0, q};
   assign r     = d[Q_LEN] ? t_i : d[Q_LEN-1:0];

   generate
      if (FF_SUB != 0) begin : g_sub_ff
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               push_vld <= 1'b0;
               push_dat <= '0;
            end else begin
               push_vld <= t_vld;
               push_dat <= r;
            end
         end
      end else begin : g_sub_comb
         assign push_vld = t_vld;
         assign push_dat = r;
      end
   endgenerate

   logic [Q_LEN-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [PW:0]      count;
   logic [PW:0]      count_nxt;
   logic             full;
   logic             wr_en;
   logic             head_is_push;

   assign full  = (count == CNT_MAX);
   assign wr_en = push_vld & (~full | pop);

   always_comb begin
      count_nxt = count;
      if (wr_en & ~pop) count_nxt = count + CNT_ONE;
      else if (pop & ~wr_en) count_nxt = count - CNT_ONE;
      rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
      // The pushed word becomes the head only when it is the sole entry left.
      head_is_push = wr_en & (count_nxt == CNT_ONE);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         res_o       <= '0;
         res_valid_o <= 1'b0;
         ovf_err_o   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr      <= rd_ptr_nxt;
         count       <= count_nxt;
         res_valid_o <= (count_nxt != '0);
         if (head_is_push) res_o <= push_dat;
         else if (count_nxt != '0) res_o <= mem[rd_ptr_nxt];
         if (push_vld & full & ~pop) ovf_err_o <= 1'b1;
      end
   end
endmodule
